// File: rtl/fdtd_field_buffer_mc.sv
// Ping-pong FDTD field store: per channel, OLD bank serves compute reads and bulk load, NEW bank takes compute writes and bulk drain.
// Reads return one cycle after request; drain output holds while the sink stalls, one word per cycle under sustained ready.
module fdtd_field_buffer_mc #(
   parameter int  DATA_WIDTH = 32,
   parameter int  ADDR_WIDTH = 6,
   parameter int  DEPTH      = 64,
   parameter int  NUM_CH     = 2,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                           CLK,
   input  logic                           RST_N,
   input  logic [ADDR_WIDTH:0]            size_i,
   input  logic [CH_W-1:0]                ch_sel_i,
   input  logic                           load_start_i,
   input  logic                           load_valid_i,
   input  logic [DATA_WIDTH-1:0]          load_data_i,
   input  logic                           drain_start_i,
   input  logic                           drain_ready_i,
   output logic                           drain_valid_o,
   output logic [DATA_WIDTH-1:0]          drain_data_o,
   input  logic                           swap_i,
   input  logic [NUM_CH-1:0]              rd_en_i,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]   rd_addr_i,
   output logic [NUM_CH*DATA_WIDTH-1:0]   rd_data_o,
   input  logic [NUM_CH-1:0]              wr_en_i,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]   wr_addr_i,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   wr_data_i,
   output logic                           bank_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           err_o
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

   state_t                        state_q;
   logic [ADDR_WIDTH:0]           cnt_q;
   logic [ADDR_WIDTH:0]           size_q;
   logic [CH_W-1:0]               ch_q;
   logic                          bank_q;
   logic                          err_q;
   logic                          done_q;
   logic                          dvld_q;
   logic [DATA_WIDTH-1:0]         ddat_q;
   logic [NUM_CH*DATA_WIDTH-1:0]  rd_data_q;

   logic [DATA_WIDTH-1:0] mem_a [NUM_CH][DEPTH];
   logic [DATA_WIDTH-1:0] mem_b [NUM_CH][DEPTH];

   logic [NUM_CH-1:0]     old_we;
   logic [NUM_CH-1:0]     new_we;
   logic [NUM_CH-1:0]     a_we;
   logic [NUM_CH-1:0]     b_we;
   logic [ADDR_WIDTH-1:0] a_addr [NUM_CH];
   logic [ADDR_WIDTH-1:0] b_addr [NUM_CH];
   logic [DATA_WIDTH-1:0] a_dat  [NUM_CH];
   logic [DATA_WIDTH-1:0] b_dat  [NUM_CH];

   logic [ADDR_WIDTH-1:0] cnt_addr;
   logic                  size_ok;
   logic                  load_wr;
   logic                  drain_issue;
   logic                  drain_last;

   assign cnt_addr    = cnt_q[ADDR_WIDTH-1:0];
   assign size_ok     = (size_i != '0) && (size_i <= DEPTH_W);
   assign load_wr     = (state_q == S_LOAD) && load_valid_i;
   assign drain_issue = (state_q == S_DRAIN) && (cnt_q < size_q) && (!dvld_q || drain_ready_i);
   // All words issued and the last one is being accepted.
   assign drain_last  = (state_q == S_DRAIN) && dvld_q && drain_ready_i && (cnt_q == size_q);

   // Route load writes to the OLD bank and compute writes to the NEW bank.
   always_comb begin
      old_we = '0;
      new_we = '0;
      a_we   = '0;
      b_we   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         old_we[c] = load_wr && (ch_q == CH_W'(c));
         new_we[c] = wr_en_i[c] && (32'(wr_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]) < DEPTH);
         a_we[c]   = bank_q ? new_we[c] : old_we[c];
         b_we[c]   = bank_q ? old_we[c] : new_we[c];
         a_addr[c] = bank_q ? wr_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH] : cnt_addr;
         b_addr[c] = bank_q ? cnt_addr : wr_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
         a_dat[c]  = bank_q ? wr_data_i[c*DATA_WIDTH +: DATA_WIDTH] : load_data_i;
         b_dat[c]  = bank_q ? load_data_i : wr_data_i[c*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge CLK) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (a_we[c]) mem_a[c][a_addr[c]] <= a_dat[c];
         if (b_we[c]) mem_b[c][b_addr[c]] <= b_dat[c];
      end
   end

   // Compute reads see the pre-write contents of a word written in the same cycle.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_data_q <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (rd_en_i[c]) begin
               if (32'(rd_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]) < DEPTH)
                  rd_data_q[c*DATA_WIDTH +: DATA_WIDTH] <= bank_q ?
                     mem_b[c][rd_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]] :
                     mem_a[c][rd_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]];
               else
                  rd_data_q[c*DATA_WIDTH +: DATA_WIDTH] <= '0;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         size_q  <= '0;
         ch_q    <= '0;
         bank_q  <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         dvld_q  <= 1'b0;
         ddat_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (swap_i) bank_q <= ~bank_q;
               if (load_start_i) begin
                  if (drain_start_i) err_q <= 1'b1;
                  if (size_ok) begin
                     size_q  <= size_i;
                     ch_q    <= ch_sel_i;
                     cnt_q   <= '0;
                     state_q <= S_LOAD;
                  end else begin
                     err_q <= 1'b1;
                  end
               end else if (drain_start_i) begin
                  if (size_ok) begin
                     size_q  <= size_i;
                     ch_q    <= ch_sel_i;
                     cnt_q   <= '0;
                     state_q <= S_DRAIN;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (swap_i || load_start_i || drain_start_i) err_q <= 1'b1;
               if (load_valid_i) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == size_q - 1'b1) begin
                     state_q <= S_IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (swap_i || load_start_i || drain_start_i) err_q <= 1'b1;
               if (drain_last) begin
                  dvld_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (drain_issue) begin
                  dvld_q <= 1'b1;
                  ddat_q <= bank_q ? mem_a[ch_q][cnt_addr] : mem_b[ch_q][cnt_addr];
                  cnt_q  <= cnt_q + 1'b1;
               end else if (dvld_q && drain_ready_i) begin
                  dvld_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign drain_valid_o = dvld_q;
   assign drain_data_o  = ddat_q;
   assign rd_data_o     = rd_data_q;
   assign bank_o        = bank_q;
   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = done_q | drain_last;
   assign err_o         = err_q;

endmodule

// File: tb/tb_fdtd_field_buffer_mc.sv
// Scoreboarded bench for fdtd_field_buffer_mc: stimulus pushes expected words from a bank-array model,
// monitors pop and compare on drain handshakes and one cycle after compute reads.
module tb_fdtd_field_buffer_mc;
   localparam int DW = 32;
   localparam int AW = 6;
   localparam int DEPTH = 64;
   localparam int NCH = 2;
   localparam int CW = 1;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic [AW:0]       size_i = '0;
   logic [CW-1:0]     ch_sel_i = '0;
   logic              load_start_i = 1'b0, load_valid_i = 1'b0;
   logic [DW-1:0]     load_data_i = '0;
   logic              drain_start_i = 1'b0, drain_ready_i = 1'b0;
   logic              drain_valid_o;
   logic [DW-1:0]     drain_data_o;
   logic              swap_i = 1'b0;
   logic [NCH-1:0]    rd_en_i = '0, wr_en_i = '0;
   logic [NCH*AW-1:0] rd_addr_i = '0, wr_addr_i = '0;
   logic [NCH*DW-1:0] rd_data_o;
   logic [NCH*DW-1:0] wr_data_i = '0;
   logic              bank_o, busy_o, done_o, err_o;

   always #5 CLK = ~CLK;

   fdtd_field_buffer_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_CH(NCH)) dut (
      .CLK(CLK), .RST_N(RST_N), .size_i(size_i), .ch_sel_i(ch_sel_i),
      .load_start_i(load_start_i), .load_valid_i(load_valid_i), .load_data_i(load_data_i),
      .drain_start_i(drain_start_i), .drain_ready_i(drain_ready_i),
      .drain_valid_o(drain_valid_o), .drain_data_o(drain_data_o), .swap_i(swap_i),
      .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
      .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .bank_o(bank_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

   // Reference model: physical bank 0 = A, 1 = B; OLD is phys[mbank].
   logic [DW-1:0] mdl [NCH][2][DEPTH];
   int mbank = 0;

   typedef struct { logic [DW-1:0] dat; bit last; } dexp_t;
   typedef struct { int ch; logic [DW-1:0] dat; } rexp_t;
   dexp_t dq[$];
   rexp_t rq[$];

   int n_cmp = 0, n_bad = 0;
   int done_cnt = 0, busy_cyc = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: drain handshakes, stall stability, compute read returns.
   initial begin
      logic [NCH-1:0] rd_pend;
      bit prev_stall;
      logic [DW-1:0] prev_dat;
      dexp_t e;
      rexp_t r;
      rd_pend = '0;
      prev_stall = 0;
      prev_dat = '0;
      forever begin
         @(negedge CLK);
         if (done_o) done_cnt++;
         if (busy_o) busy_cyc++;
         for (int c = 0; c < NCH; c++) begin
            if (rd_pend[c]) begin
               if (rq.size() == 0) chk("rd_unexpected", 1, 0);
               else begin
                  r = rq.pop_front();
                  chk("rd_ch", 64'(r.ch), 64'(c));
                  chk("rd_data", rd_data_o[c*DW +: DW], r.dat);
               end
            end
         end
         rd_pend = rd_en_i;
         if (prev_stall) begin
            chk("hold_vld", drain_valid_o, 1);
            chk("hold_dat", drain_data_o, prev_dat);
         end
         if (drain_valid_o && drain_ready_i) begin
            if (dq.size() == 0) chk("drain_unexpected", 1, 0);
            else begin
               e = dq.pop_front();
               chk("drain_dat", drain_data_o, e.dat);
               chk("drain_done_pulse", done_o, e.last);
            end
         end
         prev_stall = drain_valid_o && !drain_ready_i;
         prev_dat = drain_data_o;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic cwrite(input int ch, input int addr, input logic [DW-1:0] d);
      wr_en_i = '0;
      wr_en_i[ch] = 1'b1;
      wr_addr_i[ch*AW +: AW] = AW'(addr);
      wr_data_i[ch*DW +: DW] = d;
      mdl[ch][1-mbank][addr] = d;
      tick;
      wr_en_i = '0;
   endtask

   task automatic cread(input int ch, input int addr);
      rexp_t r;
      rd_en_i = '0;
      rd_en_i[ch] = 1'b1;
      rd_addr_i[ch*AW +: AW] = AW'(addr);
      r.ch = ch;
      r.dat = mdl[ch][mbank][addr];
      rq.push_back(r);
      tick;
      rd_en_i = '0;
   endtask

   task automatic wait_done(input int base, input string nm);
      int k;
      k = 0;
      while (done_cnt == base && k < 300) begin tick; k++; end
      tick;
      chk({nm, "_done_count"}, 64'(done_cnt - base), 1);
   endtask

   // mode: 0 valid every cycle, 1 valid every other cycle (gap first), 2 random gaps plus colliding reads
   task automatic do_load(input int ch, input int size, input int mode, input bit incr, input bit swp);
      int i, cyc, base;
      bit v;
      logic [DW-1:0] d;
      rexp_t r;
      size_i = (AW+1)'(size);
      ch_sel_i = CW'(ch);
      load_start_i = 1'b1;
      swap_i = swp;
      if (swp) mbank ^= 1;
      tick;
      load_start_i = 1'b0;
      swap_i = 1'b0;
      base = done_cnt;
      i = 0;
      cyc = 0;
      while (i < size && cyc < 4*size + 8) begin
         rd_en_i = '0;
         case (mode)
            0: v = 1'b1;
            1: v = (cyc % 2 == 1);
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         load_valid_i = v;
         if (v) begin
            d = incr ? DW'(i + 1) : $urandom;
            load_data_i = d;
            if (mode == 2 && $urandom_range(0, 1) == 1) begin
               rd_en_i[ch] = 1'b1;
               rd_addr_i[ch*AW +: AW] = AW'(i);
               r.ch = ch;
               r.dat = mdl[ch][mbank][i];
               rq.push_back(r);
            end
            mdl[ch][mbank][i] = d;
            i++;
         end
         tick;
         cyc++;
      end
      load_valid_i = 1'b0;
      rd_en_i = '0;
      wait_done(base, "load");
   endtask

   // mode: 0 ready always, 1 ready toggling 1,0,1,0, 2 random ready
   task automatic do_drain(input int ch, input int size, input int mode);
      int k, base;
      dexp_t e;
      for (int i = 0; i < size; i++) begin
         e.dat = mdl[ch][1-mbank][i];
         e.last = (i == size - 1);
         dq.push_back(e);
      end
      size_i = (AW+1)'(size);
      ch_sel_i = CW'(ch);
      drain_start_i = 1'b1;
      drain_ready_i = 1'b1;
      tick;
      drain_start_i = 1'b0;
      base = done_cnt;
      k = 0;
      while (done_cnt == base && k < 600) begin
         case (mode)
            0: drain_ready_i = 1'b1;
            1: drain_ready_i = (k % 2 == 0);
            default: drain_ready_i = 1'($urandom_range(0, 1));
         endcase
         tick;
         k++;
      end
      drain_ready_i = 1'b0;
      tick;
      chk("drain_done_count", 64'(done_cnt - base), 1);
      chk("drain_queue_empty", 64'(dq.size()), 0);
      chk("drain_vld_after", drain_valid_o, 0);
   endtask

   initial begin
      int base, bbase;
      logic [DW-1:0] d;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_bank", bank_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_dvld", drain_valid_o, 0);
      chk("rst_ddat", drain_data_o, 0);
      chk("rst_rdat", rd_data_o, 0);
      RST_N = 1'b1;
      tick;

      // Fill every bank of every channel so the model is fully defined.
      for (int ph = 0; ph < 2; ph++) begin
         for (int a = 0; a < DEPTH; a++) begin
            for (int c = 0; c < NCH; c++) begin
               d = $urandom;
               wr_en_i[c] = 1'b1;
               wr_addr_i[c*AW +: AW] = AW'(a);
               wr_data_i[c*DW +: DW] = d;
               mdl[c][1-mbank][a] = d;
            end
            tick;
         end
         wr_en_i = '0;
         swap_i = 1'b1;
         mbank ^= 1;
         tick;
         swap_i = 1'b0;
      end
      chk("fill_bank", bank_o, 0);

      // Gapped load of 1..4 into channel 0.
      bbase = busy_cyc;
      do_load(0, 4, 1, 1'b1, 1'b0);
      chk("load4_busy_cycles", 64'(busy_cyc - bbase), 8);
      for (int a = 0; a < 4; a++) cread(0, a);

      // Compute-written NEW words drained with toggling ready.
      cwrite(1, 0, 32'hA);
      cwrite(1, 1, 32'hB);
      cwrite(1, 2, 32'hC);
      do_drain(1, 3, 1);
      chk("err_clean", err_o, 0);

      // Swap exposes compute-written NEW data as OLD.
      cwrite(0, 5, 32'h55);
      swap_i = 1'b1;
      mbank ^= 1;
      tick;
      swap_i = 1'b0;
      chk("swap_bank", bank_o, 1);
      cread(0, 5);
      tick;

      // Swap together with a load start: load targets post-swap OLD bank.
      do_load(1, 5, 2, 1'b0, 1'b1);
      chk("swap_start_bank", bank_o, 64'(mbank));
      for (int a = 0; a < 5; a++) cread(1, a);

      // Illegal commands during LOAD and a zero-size start.
      size_i = 3;
      ch_sel_i = 0;
      load_start_i = 1'b1;
      tick;
      load_start_i = 1'b0;
      base = done_cnt;
      for (int i = 0; i < 3; i++) begin
         d = $urandom;
         load_valid_i = 1'b1;
         load_data_i = d;
         mdl[0][mbank][i] = d;
         swap_i = (i == 0);
         drain_start_i = (i == 1);
         if (i == 1) size_i = 5;
         tick;
      end
      load_valid_i = 1'b0;
      swap_i = 1'b0;
      drain_start_i = 1'b0;
      wait_done(base, "errload");
      chk("err_set", err_o, 1);
      chk("err_bank_kept", bank_o, 64'(mbank));
      size_i = 0;
      load_start_i = 1'b1;
      tick;
      load_start_i = 1'b0;
      chk("size0_rejected", busy_o, 0);
      for (int a = 0; a < 3; a++) cread(0, a);
      tick;

      // Randomized mix of operations.
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 4))
            0: do_load($urandom_range(0, 1), $urandom_range(1, 16), 2, 1'b0, 1'($urandom_range(0, 1)));
            1: do_drain($urandom_range(0, 1), $urandom_range(1, 16), 2);
            2: begin
               swap_i = 1'b1;
               mbank ^= 1;
               tick;
               swap_i = 1'b0;
               chk("rand_swap_bank", bank_o, 64'(mbank));
            end
            3: repeat (4) cwrite($urandom_range(0, 1), $urandom_range(0, DEPTH-1), $urandom);
            default: repeat (4) cread($urandom_range(0, 1), $urandom_range(0, DEPTH-1));
         endcase
      end
      tick;

      // Reset in the middle of a drain.
      for (int i = 0; i < 10; i++) begin
         dexp_t e;
         e.dat = mdl[0][1-mbank][i];
         e.last = (i == 9);
         dq.push_back(e);
      end
      size_i = 10;
      ch_sel_i = 0;
      drain_start_i = 1'b1;
      drain_ready_i = 1'b1;
      tick;
      drain_start_i = 1'b0;
      repeat (4) tick;
      base = done_cnt;
      RST_N = 1'b0;
      #1;
      chk("mrst_dvld", drain_valid_o, 0);
      chk("mrst_ddat", drain_data_o, 0);
      chk("mrst_rdat", rd_data_o, 0);
      chk("mrst_busy", busy_o, 0);
      chk("mrst_done", done_o, 0);
      chk("mrst_err", err_o, 0);
      chk("mrst_bank", bank_o, 0);
      drain_ready_i = 1'b0;
      dq.delete();
      mbank = 0;
      repeat (2) tick;
      RST_N = 1'b1;
      repeat (3) tick;
      chk("mrst_no_done", 64'(done_cnt - base), 0);

      // Full-depth drain after reset, then an oversize start.
      for (int a = 0; a < DEPTH; a++) cwrite(1, a, $urandom);
      do_drain(1, DEPTH, 0);
      size_i = (AW+1)'(DEPTH + 1);
      ch_sel_i = 1;
      drain_start_i = 1'b1;
      tick;
      drain_start_i = 1'b0;
      chk("oversize_rejected", busy_o, 0);
      chk("oversize_err", err_o, 1);
      repeat (3) tick;
      chk("rd_queue_empty", 64'(rq.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
